// File: rtl/difftest_commit_queue.sv
// Retire-event queue between the core and the difftest harness: buffers commits, mirrors the GPR
// file in retire order, and turns ebreak / commit starvation into sticky halt / timeout status.
module difftest_commit_queue #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned NR_GPR   = 32,
   parameter int unsigned TIMEOUT  = 4096,
   parameter int unsigned EXIT_REG = 10
) (
   input  logic                      clock,
   input  logic                      reset,

   input  logic                      commit_valid,
   output logic                      commit_ready,
   input  logic [XLEN-1:0]           commit_pc,
   input  logic [XLEN-1:0]           commit_npc,
   input  logic [31:0]               commit_inst,
   input  logic                      commit_wen,
   input  logic [$clog2(NR_GPR)-1:0] commit_waddr,
   input  logic [XLEN-1:0]           commit_wdata,
   input  logic                      commit_is_break,

   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [XLEN-1:0]           trace_pc,
   output logic [XLEN-1:0]           trace_npc,
   output logic [31:0]               trace_inst,
   output logic                      trace_wen,
   output logic [$clog2(NR_GPR)-1:0] trace_waddr,
   output logic [XLEN-1:0]           trace_wdata,
   output logic                      trace_is_break,

   input  logic [$clog2(NR_GPR)-1:0] gpr_raddr,
   output logic [XLEN-1:0]           gpr_rdata,

   output logic                      halted,
   output logic [XLEN-1:0]           halt_code,
   output logic                      timeout,
   output logic [63:0]               cycle_cnt,
   output logic [63:0]               instr_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned GW = $clog2(NR_GPR);
   // TIMEOUT-1 always fits in clog2(TIMEOUT) bits
   localparam int unsigned WW = $clog2(TIMEOUT);
   localparam int unsigned EW = 3 * XLEN + 32 + GW + 2;
   localparam logic [GW-1:0] ExitIdx = GW'(EXIT_REG);
   localparam logic [WW-1:0] WdLast  = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StRun, StDrain, StHalt, StTimeout} state_e;

   state_e          state_q, state_d;
   logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   mem_d [DEPTH];
   logic [XLEN-1:0] gpr_q [NR_GPR];
   logic [XLEN-1:0] gpr_d [NR_GPR];
   logic [WW-1:0]   wd_q, wd_d;
   logic            halted_q, halted_d;
   logic            timeout_q, timeout_d;
   logic [XLEN-1:0] halt_code_q, halt_code_d;
   logic [63:0]     cycle_cnt_q, cycle_cnt_d;
   logic [63:0]     instr_cnt_q, instr_cnt_d;

   logic            full, empty, push, pop;
   logic [EW-1:0]   commit_entry, head_entry;

   always_comb begin
      full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
      empty = (wptr_q == rptr_q);
      commit_ready = (state_q == StRun) && !full;
      trace_valid  = !empty;
      push = commit_valid && commit_ready;
      pop  = trace_valid && trace_ready;
      commit_entry = {commit_pc, commit_npc, commit_inst, commit_wen, commit_waddr, commit_wdata,
                      commit_is_break};
      head_entry = mem_q[rptr_q[AW-1:0]];
   end

   assign {trace_pc, trace_npc, trace_inst, trace_wen, trace_waddr, trace_wdata,
           trace_is_break} = head_entry;

   assign gpr_rdata = (gpr_raddr == '0) ? '0 : gpr_q[gpr_raddr];
   assign halted    = halted_q;
   assign halt_code = halt_code_q;
   assign timeout   = timeout_q;
   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      mem_d       = mem_q;
      gpr_d       = gpr_q;
      wd_d        = wd_q;
      halted_d    = halted_q;
      timeout_d   = timeout_q;
      halt_code_d = halt_code_q;
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;

      if (push) begin
         mem_d[wptr_q[AW-1:0]] = commit_entry;
         wptr_d = wptr_q + (AW+1)'(1);
      end

      if (pop) begin
         rptr_d      = rptr_q + (AW+1)'(1);
         instr_cnt_d = instr_cnt_q + 64'd1;
         if (trace_wen && (trace_waddr != '0)) begin
            gpr_d[trace_waddr] = trace_wdata;
         end
      end

      if ((state_q == StRun) || (state_q == StDrain)) begin
         cycle_cnt_d = cycle_cnt_q + 64'd1;
      end

      unique case (state_q)
         StRun: begin
            // A push always clears the watchdog, so a break on the firing cycle wins.
            if (push) begin
               wd_d = '0;
               if (commit_is_break) begin
                  state_d = StDrain;
               end
            end else if (wd_q == WdLast) begin
               state_d   = StTimeout;
               timeout_d = 1'b1;
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end
         StDrain: begin
            // The break is the last entry queued, so empty means it has already popped.
            if (empty) begin
               state_d     = StHalt;
               halted_d    = 1'b1;
               halt_code_d = gpr_q[ExitIdx];
            end
         end
         StHalt, StTimeout: ;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StRun;
         wptr_q      <= '0;
         rptr_q      <= '0;
         wd_q        <= '0;
         halted_q    <= 1'b0;
         timeout_q   <= 1'b0;
         halt_code_q <= '0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         for (int i = 0; i < int'(NR_GPR); i++) gpr_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         wd_q        <= wd_d;
         halted_q    <= halted_d;
         timeout_q   <= timeout_d;
         halt_code_q <= halt_code_d;
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
         mem_q       <= mem_d;
         gpr_q       <= gpr_d;
      end
   end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue: ordering, full/wrap, shadow GPRs, halt and watchdog.
module tb_difftest_commit_queue;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 8;

   logic            clock, reset;
   logic            commit_valid, commit_ready;
   logic [63:0]     commit_pc, commit_npc, commit_wdata;
   logic [31:0]     commit_inst;
   logic            commit_wen, commit_is_break;
   logic [4:0]      commit_waddr;
   logic            trace_valid, trace_ready;
   logic [63:0]     trace_pc, trace_npc, trace_wdata;
   logic [31:0]     trace_inst;
   logic            trace_wen, trace_is_break;
   logic [4:0]      trace_waddr;
   logic [4:0]      gpr_raddr;
   logic [63:0]     gpr_rdata;
   logic            halted, timeout;
   logic [63:0]     halt_code, cycle_cnt, instr_cnt;

   int checks   = 0;
   int failures = 0;

   difftest_commit_queue #(
      .XLEN(XLEN), .DEPTH(DEPTH), .NR_GPR(32), .TIMEOUT(16), .EXIT_REG(10)
   ) u_dut (
      .clock(clock), .reset(reset),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_pc(commit_pc), .commit_npc(commit_npc), .commit_inst(commit_inst),
      .commit_wen(commit_wen), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
      .commit_is_break(commit_is_break),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_npc(trace_npc), .trace_inst(trace_inst),
      .trace_wen(trace_wen), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata),
      .trace_is_break(trace_is_break),
      .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
      .halted(halted), .halt_code(halt_code), .timeout(timeout),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic wen,
                        input logic [4:0] wa, input logic [63:0] wd, input logic brk);
      commit_valid    = v;
      commit_pc       = pc;
      commit_npc      = pc + 64'd4;
      commit_inst     = brk ? 32'h0010_0073 : 32'h0000_0013;
      commit_wen      = wen;
      commit_waddr    = wa;
      commit_wdata    = wd;
      commit_is_break = brk;
   endtask

   task automatic do_reset();
      drive(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      trace_ready = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // e0 writes x10=0, e1 writes x<r1>=v1, then ebreak; harness stalls until all three are queued.
   task automatic halt_case(input logic [4:0] r1, input logic [63:0] v1, input logic [63:0] code);
      do_reset();
      drive(1'b1, 64'h100, 1'b1, 5'd10, 64'd0, 1'b0);
      tick();
      drive(1'b1, 64'h104, 1'b1, r1, v1, 1'b0);
      tick();
      drive(1'b1, 64'h108, 1'b0, 5'd0, 64'd0, 1'b1);
      #1 check("brk_accept", commit_ready, 1);
      tick();
      drive(1'b1, 64'h10c, 1'b0, 5'd0, 64'd0, 1'b0);
      trace_ready = 1'b1;
      #1 check("drain_ready", commit_ready, 0);
      check("drain_head", trace_pc, 64'h100);
      tick();
      commit_valid = 1'b0;
      tick();
      #1 check("brk_head", trace_is_break, 1);
      check("halt_early", halted, 0);
      tick();
      tick();
      #1 check("halted", halted, 1);
      check("halt_code", halt_code, code);
      check("halt_cycles", cycle_cnt, 64'd7);
      check("halt_instrs", instr_cnt, 64'd3);
      tick();
      #1 check("halt_cyc_frozen", cycle_cnt, 64'd7);
      check("halt_ready", commit_ready, 0);
   endtask

   logic [4:0]  wa_t [3];
   logic [63:0] wd_t [3];

   initial begin
      wa_t[0] = 5'd5; wa_t[1] = 5'd6; wa_t[2] = 5'd0;
      wd_t[0] = 64'd1; wd_t[1] = 64'd2; wd_t[2] = 64'd7;
      gpr_raddr = 5'd0;

      // Reset values
      do_reset();
      check("rst_ready", commit_ready, 1);
      check("rst_tvalid", trace_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_timeout", timeout, 0);
      check("rst_cycles", cycle_cnt, 0);
      check("rst_instrs", instr_cnt, 0);

      // Three commits streaming straight through
      trace_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b1, wa_t[i], wd_t[i], 1'b0);
         gpr_raddr = 5'd5;
         #1 check("s1_ready", commit_ready, 1);
         if (i == 0) check("s1_latency", trace_valid, 0);
         else check("s1_order", trace_pc, 64'h8000_0000 + 64'(4 * (i - 1)));
         if (i == 1) check("s1_prewrite", gpr_rdata, 64'd0);
         tick();
      end
      commit_valid = 1'b0;
      #1 check("s1_last", trace_pc, 64'h8000_0008);
      check("s1_gpr5_now", gpr_rdata, 64'd1);
      tick();
      #1 check("s1_empty", trace_valid, 0);
      check("s1_instrs", instr_cnt, 64'd3);
      gpr_raddr = 5'd6;
      #1 check("s1_gpr6", gpr_rdata, 64'd2);
      gpr_raddr = 5'd0;
      #1 check("s1_gpr0", gpr_rdata, 64'd0);

      // Fill past capacity with the harness stalled; pointers start at 3 so indices wrap
      trace_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive(1'b1, 64'h1000 + 64'(4 * i), 1'b0, 5'd0, 64'd0, 1'b0);
         #1 check("s2_ready", commit_ready, (i < DEPTH));
         tick();
      end
      commit_valid = 1'b0;
      trace_ready  = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
         #1 check("s2_valid", trace_valid, 1);
         check("s2_order", trace_pc, 64'h1000 + 64'(4 * j));
         tick();
      end
      #1 check("s2_empty", trace_valid, 0);
      check("s2_instrs", instr_cnt, 64'd11);

      // Full queue with push and pop requested together: pop only
      trace_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 64'h2000 + 64'(4 * i), 1'b0, 5'd0, 64'd0, 1'b0);
         tick();
      end
      drive(1'b1, 64'h2020, 1'b0, 5'd0, 64'd0, 1'b0);
      trace_ready = 1'b1;
      #1 check("s3_full_ready", commit_ready, 0);
      check("s3_full_head", trace_pc, 64'h2000);
      tick();
      trace_ready = 1'b0;
      #1 check("s3_ready_after", commit_ready, 1);
      tick();
      commit_valid = 1'b0;
      trace_ready  = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
         #1 check("s3_order", trace_pc, 64'h2004 + 64'(4 * j));
         tick();
      end
      #1 check("s3_empty", trace_valid, 0);
      check("s3_instrs", instr_cnt, 64'd20);

      // Reset discards queued entries
      trace_ready = 1'b0;
      drive(1'b1, 64'h3000, 1'b0, 5'd0, 64'd0, 1'b0);
      tick();
      tick();
      commit_valid = 1'b0;
      #1 check("rd_queued", trace_valid, 1);
      trace_ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1 check("rd_discard", trace_valid, 0);
      check("rd_instrs", instr_cnt, 64'd0);

      // Halt with a0 = 0, then with a0 = 0x2A from a queued write
      halt_case(5'd1, 64'h11, 64'd0);
      halt_case(5'd10, 64'h2A, 64'h2A);

      // Watchdog fires after 16 idle cycles
      do_reset();
      repeat (15) tick();
      #1 check("wd_early", timeout, 0);
      tick();
      #1 check("wd_fired", timeout, 1);
      check("wd_ready", commit_ready, 0);
      check("wd_cycles", cycle_cnt, 64'd16);
      tick();
      tick();
      #1 check("wd_cyc_frozen", cycle_cnt, 64'd16);
      reset = 1'b1;
      tick();
      #1 check("wd_rst_timeout", timeout, 0);
      check("wd_rst_cycles", cycle_cnt, 64'd0);
      check("wd_rst_ready", commit_ready, 1);
      check("wd_rst_halted", halted, 0);
      check("wd_rst_code", halt_code, 64'd0);
      reset = 1'b0;

      // Break on the firing cycle takes priority over the watchdog
      do_reset();
      repeat (15) tick();
      drive(1'b1, 64'h4000, 1'b0, 5'd0, 64'd0, 1'b1);
      #1 check("pri_accept", commit_ready, 1);
      tick();
      commit_valid = 1'b0;
      #1 check("pri_timeout", timeout, 0);
      check("pri_ready", commit_ready, 0);
      check("pri_queued", trace_valid, 1);
      trace_ready = 1'b1;
      tick();
      tick();
      #1 check("pri_halted", halted, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
